// File: rtl/hazard_sequencer.sv
// Pipeline control for the 5-stage RV32I core. Drives the PC and pipeline-register strobes and
// the EX forwarding selects from shadow copies of each stage's destination-register info.
module hazard_sequencer #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_result_src,
  input  logic [1:0]            ex_pc_src,
  input  logic                  mem_access,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_clr,
  output logic                  idex_en,
  output logic                  idex_clr,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  memwb_clr,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {
    StRun      = 2'b00,
    StLuStall  = 2'b01,
    StMemWait  = 2'b10
  } state_e;

  localparam logic [1:0] RsrcMem = 2'b01;
  localparam logic [1:0] PcNext  = 2'b00;
  localparam logic [1:0] FwdNone = 2'b00;
  localparam logic [1:0] FwdAlu  = 2'b01;
  localparam logic [1:0] FwdWb   = 2'b10;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e state_q, state_d;

  logic [REG_ADDR_W-1:0] idex_rd_q, idex_rs1_q, idex_rs2_q;
  logic                  idex_rw_q;
  logic [1:0]            idex_rsrc_q;
  logic [REG_ADDR_W-1:0] exmem_rd_q;
  logic                  exmem_rw_q;
  logic [1:0]            exmem_rsrc_q;
  logic [REG_ADDR_W-1:0] memwb_rd_q;
  logic                  memwb_rw_q;

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_wait, redirect, load_use, flush_inc;

  assign mem_wait = mem_access && !dmem_ready;
  assign redirect = ex_pc_src != PcNext;
  assign load_use = (idex_rsrc_q == RsrcMem) && idex_rw_q && (idex_rd_q != '0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == idex_rd_q)) ||
                     (id_use_rs2 && (id_rs2 == idex_rd_q)));

  // A redirect held off by mem_wait stays visible on ex_pc_src because EX is frozen,
  // so it is applied naturally on the first cycle the memory completes.
  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_en   = 1'b1;
    idex_clr  = 1'b0;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    memwb_clr = 1'b0;
    flush_inc = 1'b0;
    state_d   = StRun;
    if (mem_wait) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_clr = 1'b1;
      state_d   = StMemWait;
    end else if (redirect) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      flush_inc = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
      state_d  = StLuStall;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  mem_rw,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic [1:0]            mem_rsrc,
    input logic                  wb_rw,
    input logic [REG_ADDR_W-1:0] wb_rd
  );
    // MEM stage holds the newer value; a load there is not yet available.
    if (mem_rw && (mem_rd != '0) && (mem_rd == rs) && (mem_rsrc != RsrcMem)) begin
      return FwdAlu;
    end else if (wb_rw && (wb_rd != '0) && (wb_rd == rs)) begin
      return FwdWb;
    end
    return FwdNone;
  endfunction

  always_comb begin
    fwd_a_sel = fwd_sel(idex_rs1_q, exmem_rw_q, exmem_rd_q, exmem_rsrc_q, memwb_rw_q, memwb_rd_q);
    fwd_b_sel = fwd_sel(idex_rs2_q, exmem_rw_q, exmem_rd_q, exmem_rsrc_q, memwb_rw_q, memwb_rd_q);
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      idex_rd_q    <= '0;
      idex_rs1_q   <= '0;
      idex_rs2_q   <= '0;
      idex_rw_q    <= 1'b0;
      idex_rsrc_q  <= '0;
      exmem_rd_q   <= '0;
      exmem_rw_q   <= 1'b0;
      exmem_rsrc_q <= '0;
      memwb_rd_q   <= '0;
      memwb_rw_q   <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q <= state_d;

      if (idex_clr || (idex_en && !id_valid)) begin
        idex_rd_q   <= '0;
        idex_rs1_q  <= '0;
        idex_rs2_q  <= '0;
        idex_rw_q   <= 1'b0;
        idex_rsrc_q <= '0;
      end else if (idex_en) begin
        idex_rd_q   <= id_rd;
        idex_rs1_q  <= id_use_rs1 ? id_rs1 : '0;
        idex_rs2_q  <= id_use_rs2 ? id_rs2 : '0;
        idex_rw_q   <= id_reg_write;
        idex_rsrc_q <= id_result_src;
      end

      if (exmem_en) begin
        exmem_rd_q   <= idex_rd_q;
        exmem_rw_q   <= idex_rw_q;
        exmem_rsrc_q <= idex_rsrc_q;
      end

      if (memwb_clr) begin
        memwb_rd_q <= '0;
        memwb_rw_q <= 1'b0;
      end else if (memwb_en) begin
        memwb_rd_q <= exmem_rd_q;
        memwb_rw_q <= exmem_rw_q;
      end

      if (!pc_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CntOne;
      end
      if (flush_inc && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CntOne;
      end
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: per-cycle expectations are queued as stimulus is
// driven and compared against the DUT on the following negative clock edge.
module tb_hazard_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_result_src, ex_pc_src;
  logic       mem_access, dmem_ready;
  logic       pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en, memwb_clr;
  logic [1:0] fwd_a_sel, fwd_b_sel, state;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_sequencer #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_result_src(id_result_src),
    .ex_pc_src(ex_pc_src), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .idex_en(idex_en),
    .idex_clr(idex_clr), .exmem_en(exmem_en), .memwb_en(memwb_en), .memwb_clr(memwb_clr),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance for the saturation check.
  logic       s_mem_access, s_dmem_ready, s_zero1;
  logic [4:0] s_zero5;
  logic [1:0] s_zero2;
  logic       s_pc_en, s_ifid_en, s_ifid_clr, s_idex_en, s_idex_clr;
  logic       s_exmem_en, s_memwb_en, s_memwb_clr;
  logic [1:0] s_fwd_a_sel, s_fwd_b_sel, s_state;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  hazard_sequencer #(.REG_ADDR_W(5), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .id_valid(s_zero1), .id_rs1(s_zero5), .id_rs2(s_zero5),
    .id_use_rs1(s_zero1), .id_use_rs2(s_zero1), .id_rd(s_zero5),
    .id_reg_write(s_zero1), .id_result_src(s_zero2),
    .ex_pc_src(s_zero2), .mem_access(s_mem_access), .dmem_ready(s_dmem_ready),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_clr(s_ifid_clr), .idex_en(s_idex_en),
    .idex_clr(s_idex_clr), .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
    .memwb_clr(s_memwb_clr), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
    .state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Strobe order: pc_en ifid_en ifid_clr idex_en idex_clr exmem_en memwb_en memwb_clr
  localparam logic [7:0] SRun = 8'b1101_0110;
  localparam logic [7:0] SLu  = 8'b0001_1110;
  localparam logic [7:0] SRd  = 8'b1111_1110;
  localparam logic [7:0] SMw  = 8'b0000_0011;

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  strb;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [1:0]  st;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   step_no = 0;

  logic [7:0] strb_obs;
  assign strb_obs = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en, memwb_clr};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] strb, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [1:0] st, input int stall, input int flush);
    exp_t e;
    e.id    = '0;
    e.strb  = strb;
    e.fa    = fa;
    e.fb    = fb;
    e.st    = st;
    e.stall = 32'(stall);
    e.flush = 32'(flush);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      check_eq($sformatf("strb@%0d", e.id), 32'(strb_obs), 32'(e.strb));
      check_eq($sformatf("fwd_a@%0d", e.id), 32'(fwd_a_sel), 32'(e.fa));
      check_eq($sformatf("fwd_b@%0d", e.id), 32'(fwd_b_sel), 32'(e.fb));
      check_eq($sformatf("state@%0d", e.id), 32'(state), 32'(e.st));
      check_eq($sformatf("stall@%0d", e.id), stall_cnt, e.stall);
      check_eq($sformatf("flush@%0d", e.id), flush_cnt, e.flush);
    end
  end

  task automatic push_exp(input exp_t e);
    e.id = 8'(step_no);
    step_no++;
    sb.push_back(e);
  endtask

  task automatic step(input exp_t e);
    push_exp(e);
    @(posedge clk);
    #1;
  endtask

  task automatic id_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic rw,
                       input logic [1:0] rsrc);
    id_valid      = v;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_use_rs1    = u1;
    id_use_rs2    = u2;
    id_rd         = rd;
    id_reg_write  = rw;
    id_result_src = rsrc;
  endtask

  task automatic ctl(input logic [1:0] pcs, input logic ma, input logic rdy);
    ex_pc_src  = pcs;
    mem_access = ma;
    dmem_ready = rdy;
  endtask

  task automatic check_run_reset(input string tag);
    check_eq({tag, "_strb"}, 32'(strb_obs), 32'(SRun));
    check_eq({tag, "_fwd"}, 32'({fwd_a_sel, fwd_b_sel}), 32'(0));
    check_eq({tag, "_state"}, 32'(state), 32'(0));
    check_eq({tag, "_stall"}, stall_cnt, 32'(0));
    check_eq({tag, "_flush"}, flush_cnt, 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    id_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
    ctl(2'b00, 1'b0, 1'b1);
    s_mem_access = 1'b0;
    s_dmem_ready = 1'b0;
    s_zero1      = 1'b0;
    s_zero5      = 5'd0;
    s_zero2      = 2'b00;
    #2;
    check_run_reset("rst0");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load-use: lw x5 then add x6,x5,x1.
    id_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01);
    step(mk(SRun, 2'b00, 2'b00, 2'b00, 0, 0));
    id_in(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 2'b00);
    step(mk(SLu, 2'b00, 2'b00, 2'b00, 0, 0));
    step(mk(SRun, 2'b00, 2'b00, 2'b01, 1, 0));
    // add x6 in EX, lw in WB -> operand A from WB. ID: add x3,x1,x2.
    id_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'b00);
    step(mk(SRun, 2'b10, 2'b00, 2'b00, 1, 0));
    // ID: sub x4,x1,x3.
    id_in(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 2'b00);
    step(mk(SRun, 2'b00, 2'b00, 2'b00, 1, 0));
    // sub in EX with x3 in MEM -> operand B from ALU. ID writes x0.
    id_in(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b00);
    step(mk(SRun, 2'b00, 2'b01, 2'b00, 1, 0));
    // ID: reads x0 as rs2.
    id_in(1'b1, 5'd1, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 2'b00);
    step(mk(SRun, 2'b00, 2'b00, 2'b00, 1, 0));
    // x0 writer in MEM, EX rs2=x0 -> never forwarded. ID: A writes x7.
    id_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 2'b00);
    step(mk(SRun, 2'b00, 2'b00, 2'b00, 1, 0));
    // ID: B writes x7.
    step(mk(SRun, 2'b00, 2'b00, 2'b00, 1, 0));
    // ID: C reads x7.
    id_in(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 2'b00);
    step(mk(SRun, 2'b00, 2'b00, 2'b00, 1, 0));
    // Double match: MEM and WB both x7 -> MEM wins. ID: lw x10.
    id_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 2'b01);
    step(mk(SRun, 2'b01, 2'b00, 2'b00, 1, 0));
    // Redirect together with a load-use: redirect wins, no stall.
    id_in(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 2'b00);
    ctl(2'b01, 1'b0, 1'b1);
    step(mk(SRd, 2'b00, 2'b00, 2'b00, 1, 0));
    id_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
    ctl(2'b00, 1'b0, 1'b1);
    step(mk(SRun, 2'b00, 2'b00, 2'b00, 1, 1));

    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_run_reset("rst1");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Memory wait for 3 cycles with an indirect jump pending.
    ctl(2'b10, 1'b1, 1'b0);
    step(mk(SMw, 2'b00, 2'b00, 2'b00, 0, 0));
    step(mk(SMw, 2'b00, 2'b00, 2'b10, 1, 0));
    step(mk(SMw, 2'b00, 2'b00, 2'b10, 2, 0));
    ctl(2'b10, 1'b1, 1'b1);
    step(mk(SRd, 2'b00, 2'b00, 2'b10, 3, 0));
    ctl(2'b00, 1'b0, 1'b1);
    step(mk(SRun, 2'b00, 2'b00, 2'b00, 3, 1));

    // Reset in the middle of MEM_WAIT, between clock edges.
    ctl(2'b00, 1'b1, 1'b0);
    step(mk(SMw, 2'b00, 2'b00, 2'b00, 3, 1));
    push_exp(mk(SMw, 2'b00, 2'b00, 2'b10, 4, 1));
    @(negedge clk);
    #1;
    rst = 1'b1;
    ctl(2'b00, 1'b0, 1'b1);
    #1;
    check_run_reset("rst2");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(mk(SRun, 2'b00, 2'b00, 2'b00, 0, 0));
    step(mk(SRun, 2'b00, 2'b00, 2'b00, 0, 0));

    // Saturation on the 4-bit instance.
    s_mem_access = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check_eq("sat14", 32'(s_stall_cnt), 32'd14);
    repeat (6) @(posedge clk);
    #1;
    check_eq("sat20", 32'(s_stall_cnt), 32'd15);
    s_mem_access = 1'b0;

    @(negedge clk);
    #1;
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control block for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Generates the enable and clear strobes for the PC and every pipeline register, and the EX-stage forwarding mux selects.
- Sequences load-use stalls, branch/jump flushes and data-memory wait states.
- Keeps its own shadow copy of the destination-register info for each stage, advanced with the same strobes it drives, plus saturating performance counters.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_ADDR_W  ID source 1
id_rs2  in  REG_ADDR_W  ID source 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_rd  in  REG_ADDR_W  ID destination
id_reg_write  in  1  ID writes rd
id_result_src  in  2  ResultSource_t of ID instruction (00 ALU, 01 MEM, 10 PC4)
ex_pc_src  in  2  PCsource_t from EX (00 NEXT, 01 JUMP, 10 INDJ)
mem_access  in  1  MEM stage performs load/store
dmem_ready  in  1  data memory completes this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID enable
ifid_clr  out  1  IF/ID clear (bubble)
idex_en  out  1  ID/EX enable
idex_clr  out  1  ID/EX clear
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
memwb_clr  out  1  MEM/WB clear
fwd_a_sel  out  2  FowHaz_MUX_SEL_t for EX operand A
fwd_b_sel  out  2  FowHaz_MUX_SEL_t for EX operand B
state  out  2  FSM state (00 RUN, 01 LU_STALL, 10 MEM_WAIT)
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  taken redirects

Behaviour:
- Reset (async, rst=1): state=RUN; all shadows invalid (reg_write=0, rd=0); both counters 0. Strobe outputs follow the combinational rules below from the cleared shadows, giving pc_en=ifid_en=idex_en=exmem_en=memwb_en=1, all clears 0, fwd selects 00.
- Shadows:
  - ID/EX holds rd, reg_write, result_src, rs1, rs2 (rs fields zeroed when the matching use bit is 0). Loaded from id_* when idex_en; zeroed on idex_clr or !id_valid.
  - EX/MEM loads from ID/EX when exmem_en.
  - MEM/WB loads from EX/MEM when memwb_en; zeroed on memwb_clr.
- Hazard conditions (evaluated every cycle):
  - mem_wait = mem_access && !dmem_ready.
  - redirect = ex_pc_src != NEXT.
  - load_use = ID/EX result_src==MEM && ID/EX reg_write && ID/EX rd!=0 && id_valid && ((id_use_rs1 && id_rs1==ID/EX rd) || (id_use_rs2 && id_rs2==ID/EX rd)).
- Priority: mem_wait > redirect > load_use.
- mem_wait:
  - pc_en=ifid_en=idex_en=exmem_en=0; memwb_clr=1; next state MEM_WAIT.
  - A redirect pending in EX is held and applied on the first cycle without mem_wait.
- redirect:
  - ifid_clr=1, idex_clr=1; all enables 1; flush_cnt+1.
  - A simultaneous load_use is ignored, because its ID instruction is squashed.
- load_use:
  - pc_en=0, ifid_en=0, idex_clr=1; next state LU_STALL.
  - Exactly one bubble is inserted. Next cycle the load is in MEM and the condition deasserts.
- Otherwise: everything enabled, next state RUN.
- stall_cnt increments on every cycle with pc_en=0. Both counters saturate at all-ones.
- Forwarding, per operand X (rs from the ID/EX shadow):
  - 01 (FROM_ALU_RSLT) if EX/MEM reg_write && rd!=0 && rd==rs && result_src!=MEM. PC4 is forwarded as ALU, since the ALU computes PC+4.
  - else 10 (FROM_DTA_MEMR, the WB result) if MEM/WB reg_write && rd!=0 && rd==rs.
  - else 00.
  - The MEM stage is newest and wins; register x0 is never forwarded.
- Mid-operation reset clears all shadows and counters immediately; the next edge behaves as RUN.

Test Plan:
1. Load-use: lw x5 in EX (result_src=01, rd=5), ID add x6,x5,x1 with use_rs1=1 → one cycle of pc_en=0, ifid_en=0, idex_clr=1, state=01; next cycle fwd_a_sel=10, stall_cnt=1.
2. ALU forwarding: add x3 (rd=3, ALU) followed by sub using rs2=3 → on the sub's EX cycle fwd_b_sel=01. If rd=0 instead → fwd_b_sel=00.
3. Double match: MEM rd=7 (ALU) and WB rd=7, EX rs1=7 → fwd_a_sel=01.
4. Redirect + load_use in the same cycle: ex_pc_src=01 → ifid_clr=idex_clr=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
5. Memory wait: mem_access=1, dmem_ready=0 for 3 cycles with ex_pc_src=10 → 3 cycles with pc_en=exmem_en=0, memwb_clr=1, state=10; flush applied on cycle 4; stall_cnt=3, flush_cnt=1.
6. Reset asserted during MEM_WAIT → outputs immediately return to RUN values and counters read 0, without waiting for clk; saturation check with CNT_W=4 → 20 stalls give stall_cnt=15.
